uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT    = 868;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned UART_DATA_W             = 8;
  localparam int unsigned UART_BIT_IDX_W          = $clog2(UART_DATA_W);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count and registered full/empty.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic             full_q;
  logic             empty_q;
  logic             push_c;
  logic             pop_c;

  // Legality is judged on the registered flags, so a same-cycle pop never frees a slot.
  always_comb begin
    push_c  = wr_en & ~full_q;
    pop_c   = rd_en & ~empty_q;
    count_n = count_q;
    unique case ({push_c, pop_c})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_n;
      full_q  <= (count_n == CNT_W'(DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter  int unsigned DEPTH        = UART_FIFO_DEPTH_DEFAULT,
  localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   uart_tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_W - 1);

  uart_state_e                state_q;
  uart_state_e                state_n;
  logic [BAUD_W-1:0]          baud_q;
  logic [BAUD_W-1:0]          baud_n;
  logic [UART_BIT_IDX_W-1:0]  bit_idx_q;
  logic [UART_BIT_IDX_W-1:0]  bit_idx_n;
  logic [UART_DATA_W-1:0]     sh_q;
  logic [UART_DATA_W-1:0]     sh_n;
  logic                       tx_q;
  logic                       tx_n;
  logic                       busy_q;
  logic                       busy_n;
  logic                       overflow_q;
  logic                       baud_done_c;
  logic                       pop_c;
  logic [UART_DATA_W-1:0]     fifo_rd_data_c;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (pop_c),
    .rd_data_c (fifo_rd_data_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, pop and next-output logic; the line level follows the next state.
  always_comb begin
    state_n     = state_q;
    bit_idx_n   = bit_idx_q;
    sh_n        = sh_q;
    pop_c       = 1'b0;
    baud_done_c = (baud_q == BAUD_LAST);
    baud_n      = baud_done_c ? '0 : baud_q + BAUD_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          sh_n    = fifo_rd_data_c;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_done_c) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (baud_done_c) begin
          sh_n      = {1'b0, sh_q[UART_DATA_W-1:1]};
          bit_idx_n = bit_idx_q + UART_BIT_IDX_W'(1);
          if (bit_idx_q == BIT_LAST) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (baud_done_c) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            sh_n    = fifo_rd_data_c;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state_q) baud_n = '0;

    unique case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = sh_n[0];
      default:  tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      baud_q     <= baud_n;
      bit_idx_q  <= bit_idx_n;
      sh_q       <= sh_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      overflow_q <= overflow_q | (wr_en & fifo_full);
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign count    = fifo_count;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a line decoder feeding a byte scoreboard.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       busy;
  logic       uart_tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_end = -100;
  int frame_cnt = 0;
  int b2b_cnt = 0;
  int mon_t = 0;
  bit mon_active = 1'b0;
  logic [FRAME-1:0] mon_bits;
  logic [FRAME-1:0] exp_bits;
  logic [7:0] dbyte;
  logic [7:0] sb [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line decoder: sample every cycle, judge the whole frame once its last stop sample is in.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_t = 0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t = 0;
        mon_bits[0] = uart_tx;
        if (cyc == last_end + 1) b2b_cnt++;
      end
    end else begin
      mon_t++;
      mon_bits[mon_t] = uart_tx;
      if (mon_t == FRAME - 1) begin
        for (int k = 1; k <= 8; k++) dbyte[k-1] = mon_bits[CPB*k + 1];
        for (int i = 0; i < FRAME; i++) begin
          if (i / CPB == 0)      exp_bits[i] = 1'b0;
          else if (i / CPB == 9) exp_bits[i] = 1'b1;
          else                   exp_bits[i] = dbyte[i/CPB - 1];
        end
        check("frame_shape", 64'(mon_bits), 64'(exp_bits));
        if (sb.size() == 0) check("unexpected_frame", 64'(dbyte), 64'hFFFF);
        else check("frame_data", 64'(dbyte), 64'(sb.pop_front()));
        frame_cnt++;
        mon_active = 1'b0;
        last_end = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    wr_en = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !mon_active) done = 1'b1;
    end
    check("idle_timeout", 64'(done), 64'd1);
  endtask

  int f0;
  int b0;

  initial begin
    // 1: quiet line after reset
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", 64'(uart_tx), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_empty", 64'(empty), 64'd1);
      check("idle_count", 64'(count), 64'd0);
      check("idle_ovf", 64'(overflow), 64'd0);
    end

    // 2: single byte, exact latency and frame length
    write_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("a5_pre_tx", 64'(uart_tx), 64'd1);
    check("a5_pre_count", 64'(count), 64'd1);
    check("a5_pre_empty", 64'(empty), 64'd0);
    @(negedge clk);
    check("a5_start_tx", 64'(uart_tx), 64'd0);
    check("a5_start_busy", 64'(busy), 64'd1);
    check("a5_start_count", 64'(count), 64'd0);
    repeat (FRAME - 1) @(negedge clk);
    check("a5_last_stop_tx", 64'(uart_tx), 64'd1);
    check("a5_last_stop_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("a5_after_busy", 64'(busy), 64'd0);
    check("a5_after_tx", 64'(uart_tx), 64'd1);
    check("a5_sb_empty", 64'(sb.size()), 64'd0);

    // 3: back-to-back frames with no idle gap
    f0 = frame_cnt;
    b0 = b2b_cnt;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    wait_idle(4 * FRAME);
    check("b2b_frames", 64'(frame_cnt - f0), 64'd3);
    check("b2b_gapless", 64'(b2b_cnt - b0), 64'd2);

    // 4: fill to full, sixth write dropped, overflow sticky
    do_reset();
    f0 = frame_cnt;
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ovf", 64'(overflow), 64'd0);
    write_byte(8'h15, 1'b0);
    @(negedge clk);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_count", 64'(count), 64'd4);
    wait_idle(7 * FRAME);
    check("drop_frames", 64'(frame_cnt - f0), 64'd5);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("drain_empty", 64'(empty), 64'd1);

    // 5: reset mid-frame, then a clean frame
    do_reset();
    check("rst_clears_ovf", 64'(overflow), 64'd0);
    write_byte(8'h55, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_tx", 64'(uart_tx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_count", 64'(count), 64'd0);
    check("abort_empty", 64'(empty), 64'd1);
    f0 = frame_cnt;
    write_byte(8'h3C, 1'b1);
    wait_idle(2 * FRAME);
    check("post_abort_frames", 64'(frame_cnt - f0), 64'd1);

    // 6: write into a full FIFO on the cycle of a pop
    do_reset();
    f0 = frame_cnt;
    for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i), 1'b1);
    repeat (36) step();
    @(negedge clk);
    check("pp_pre_count", 64'(count), 64'd4);
    check("pp_pre_full", 64'(full), 64'd1);
    check("pp_pre_ovf", 64'(overflow), 64'd0);
    write_byte(8'h25, 1'b0);
    @(negedge clk);
    check("pp_ovf", 64'(overflow), 64'd1);
    check("pp_count", 64'(count), 64'd3);
    check("pp_full", 64'(full), 64'd0);
    check("pp_busy", 64'(busy), 64'd1);
    wait_idle(6 * FRAME);
    check("pp_frames", 64'(frame_cnt - f0), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
